// File: rtl/mmcm_reconfig_pkg.sv
// ============================================================================
// Module      : mmcm_reconfig_pkg
// Description : Shared types and constants for the MMCM DRP reconfiguration
//               controller (FSM states, error codes, DRP addresses, ROM entry).
//               MMCM_RECONFIG_READBACK_EN adds the CHK readback state.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package mmcm_reconfig_pkg;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_RST_ASSERT = 4'd1,
    S_RD         = 4'd2,
    S_RD_WAIT    = 4'd3,
    S_WR         = 4'd4,
    S_WR_WAIT    = 4'd5,
`ifdef MMCM_RECONFIG_READBACK_EN
    S_CHK        = 4'd6,
`endif
    S_NEXT       = 4'd7,
    S_RST_HOLD   = 4'd8,
    S_LOCK_WAIT  = 4'd9,
    S_DONE       = 4'd10,
    S_ERR        = 4'd11
  } state_t;

  localparam logic [1:0] c_ERR_NONE = 2'd0;
  localparam logic [1:0] c_ERR_DRDY = 2'd1;
  localparam logic [1:0] c_ERR_LOCK = 2'd2;
  localparam logic [1:0] c_ERR_RDBK = 2'd3;

  localparam logic [6:0] c_ADDR_CLKOUT0_REG1  = 7'h08;
  localparam logic [6:0] c_ADDR_CLKOUT0_REG2  = 7'h09;
  localparam logic [6:0] c_ADDR_CLKOUT2_REG1  = 7'h0C;
  localparam logic [6:0] c_ADDR_CLKOUT2_REG2  = 7'h0D;
  localparam logic [6:0] c_ADDR_CLKFBOUT_REG1 = 7'h14;
  localparam logic [6:0] c_ADDR_CLKFBOUT_REG2 = 7'h15;
  localparam logic [6:0] c_ADDR_DIVCLK        = 7'h16;

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
  } rom_entry_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mmcm_cfg_rom.sv
// ============================================================================
// Module      : mmcm_cfg_rom
// Description : Combinational (cfg_sel, idx) -> DRP read-modify-write entry.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mmcm_cfg_rom
  import mmcm_reconfig_pkg::*;
#(
  parameter int N_ENTRIES = 4
) (
  input  logic [1:0]  i_cfg_sel,
  input  logic [3:0]  i_idx,
  output logic [6:0]  o_addr,
  output logic [15:0] o_mask,
  output logic [15:0] o_data
);

  localparam logic [4:0] c_N = 5'(N_ENTRIES);

  logic [15:0] w_r1_data;
  logic [15:0] w_r2_data;
  logic [15:0] w_fb_data;
  logic [15:0] w_div_data;
  rom_entry_t  w_entry;

  // Divider encodings: reg1 = {high_time[11:6], low_time[5:0]}
  always_comb begin
    w_r1_data  = 16'h0041;
    w_r2_data  = 16'h0000;
    w_fb_data  = 16'h0145;
    w_div_data = 16'h1041;
    case (i_cfg_sel)
      2'd1: begin
        w_r1_data = 16'h0082; w_fb_data = 16'h0186; w_div_data = 16'h1041;
      end
      2'd2: begin
        w_r1_data = 16'h00C3; w_fb_data = 16'h01C7; w_div_data = 16'h0041;
      end
      2'd3: begin
        w_r1_data = 16'h0104; w_r2_data = 16'h0080;
        w_fb_data = 16'h0208; w_div_data = 16'h0082;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_entry = '{addr: c_ADDR_CLKFBOUT_REG2, mask: 16'hFFFF, data: 16'h0000};
    if ({1'b0, i_idx} < c_N) begin
      case (i_idx)
        4'd0: w_entry = '{addr: c_ADDR_CLKOUT0_REG1,  mask: 16'h1000, data: w_r1_data};
        4'd1: w_entry = '{addr: c_ADDR_CLKOUT0_REG2,  mask: 16'hFC00, data: w_r2_data};
        4'd2: w_entry = '{addr: c_ADDR_CLKFBOUT_REG1, mask: 16'h1000, data: w_fb_data};
        4'd3: w_entry = '{addr: c_ADDR_DIVCLK,        mask: 16'hC000, data: w_div_data};
        4'd4: w_entry = '{addr: c_ADDR_CLKOUT2_REG1,  mask: 16'h1000, data: w_r1_data};
        4'd5: w_entry = '{addr: c_ADDR_CLKOUT2_REG2,  mask: 16'hFC00, data: w_r2_data};
        4'd6: w_entry = '{addr: c_ADDR_CLKFBOUT_REG2, mask: 16'hFC00, data: 16'h0000};
        default: ;
      endcase
    end
  end

  assign o_addr = w_entry.addr;
  assign o_mask = w_entry.mask;
  assign o_data = w_entry.data;

endmodule

`default_nettype wire

// File: rtl/mmcm_reconfig_ctrl.sv
// ============================================================================
// Module      : mmcm_reconfig_ctrl
// Description : MMCM DRP reconfiguration sequencer (RMW of ROM entries, MMCM
//               reset, lock wait). MMCM_RECONFIG_READBACK_EN adds write readback.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mmcm_reconfig_ctrl
  import mmcm_reconfig_pkg::*;
#(
  parameter int N_ENTRIES    = 4,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int RST_CYCLES   = 8
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  cfg_sel,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic        mmcm_rst,
  output logic [6:0]  daddr,
  output logic [15:0] di,
  output logic        den,
  output logic        dwe,
  input  logic [15:0] do_in,
  input  logic        drdy,
  input  logic        locked,
  output logic        locked_out
);

  localparam logic [15:0] c_DRDY_LAST = 16'(DRDY_TIMEOUT - 1);
  localparam logic [15:0] c_LOCK_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] c_RST_LAST  = 16'(RST_CYCLES - 1);
  localparam logic [3:0]  c_IDX_LAST  = 4'(N_ENTRIES - 1);

  state_t      r_state;
  logic [1:0]  r_cfg;
  logic [3:0]  r_idx;
  logic [15:0] r_cnt;
  logic [15:0] r_new;
  logic        r_lock_meta;
  logic        r_lock_s;
`ifdef MMCM_RECONFIG_READBACK_EN
  logic        r_chk_sent;
`endif

  logic [6:0]  w_addr;
  logic [15:0] w_mask;
  logic [15:0] w_data;

  mmcm_cfg_rom #(.N_ENTRIES(N_ENTRIES)) u_rom (
    .i_cfg_sel (r_cfg),
    .i_idx     (r_idx),
    .o_addr    (w_addr),
    .o_mask    (w_mask),
    .o_data    (w_data)
  );

  assign locked_out = r_lock_s & ~busy;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cfg       <= 2'd0;
      r_idx       <= 4'd0;
      r_cnt       <= 16'd0;
      r_new       <= 16'd0;
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_code    <= c_ERR_NONE;
      mmcm_rst    <= 1'b1;
      daddr       <= 7'd0;
      di          <= 16'd0;
      den         <= 1'b0;
      dwe         <= 1'b0;
`ifdef MMCM_RECONFIG_READBACK_EN
      r_chk_sent  <= 1'b0;
`endif
    end else begin
      r_lock_meta <= locked;
      r_lock_s    <= r_lock_meta;
      done        <= 1'b0;
      den         <= 1'b0;
      dwe         <= 1'b0;
      case (r_state)
        S_IDLE: begin
          mmcm_rst <= 1'b0;
          if (start) begin
            r_cfg    <= cfg_sel;
            error    <= 1'b0;
            err_code <= c_ERR_NONE;
            busy     <= 1'b1;
            r_idx    <= 4'd0;
            mmcm_rst <= 1'b1;
            r_state  <= S_RST_ASSERT;
          end
        end
        S_RST_ASSERT: begin
          mmcm_rst <= 1'b1;
          r_state  <= S_RD;
        end
        S_RD: begin
          den     <= 1'b1;
          daddr   <= w_addr;
          r_cnt   <= 16'd0;
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (drdy) begin
            r_new   <= (do_in & w_mask) | w_data;
            r_state <= S_WR;
          end else if (r_cnt == c_DRDY_LAST) begin
            error <= 1'b1; err_code <= c_ERR_DRDY; busy <= 1'b0;
            mmcm_rst <= 1'b0; r_state <= S_ERR;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        S_WR: begin
          den     <= 1'b1;
          dwe     <= 1'b1;
          daddr   <= w_addr;
          di      <= r_new;
          r_cnt   <= 16'd0;
          r_state <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (drdy) begin
`ifdef MMCM_RECONFIG_READBACK_EN
            r_chk_sent <= 1'b0;
            r_state    <= S_CHK;
`else
            r_state    <= S_NEXT;
`endif
          end else if (r_cnt == c_DRDY_LAST) begin
            error <= 1'b1; err_code <= c_ERR_DRDY; busy <= 1'b0;
            mmcm_rst <= 1'b0; r_state <= S_ERR;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
`ifdef MMCM_RECONFIG_READBACK_EN
        // daddr still holds the address just written
        S_CHK: begin
          if (!r_chk_sent) begin
            den        <= 1'b1;
            r_chk_sent <= 1'b1;
            r_cnt      <= 16'd0;
          end else if (drdy) begin
            if (do_in == r_new) begin
              r_state <= S_NEXT;
            end else begin
              error <= 1'b1; err_code <= c_ERR_RDBK; busy <= 1'b0;
              mmcm_rst <= 1'b0; r_state <= S_ERR;
            end
          end else if (r_cnt == c_DRDY_LAST) begin
            error <= 1'b1; err_code <= c_ERR_DRDY; busy <= 1'b0;
            mmcm_rst <= 1'b0; r_state <= S_ERR;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
`endif
        S_NEXT: begin
          r_cnt <= 16'd0;
          if (r_idx == c_IDX_LAST) begin
            r_state <= S_RST_HOLD;
          end else begin
            r_idx   <= r_idx + 4'd1;
            r_state <= S_RD;
          end
        end
        S_RST_HOLD: begin
          if (r_cnt == c_RST_LAST) begin
            mmcm_rst <= 1'b0;
            r_cnt    <= 16'd0;
            r_state  <= S_LOCK_WAIT;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        S_LOCK_WAIT: begin
          if (r_lock_s) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end else if (r_cnt == c_LOCK_LAST) begin
            error <= 1'b1; err_code <= c_ERR_LOCK; busy <= 1'b0;
            mmcm_rst <= 1'b0; r_state <= S_ERR;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mmcm_reconfig_ctrl.sv
// ============================================================================
// Module      : tb_mmcm_reconfig_ctrl
// Description : Directed bench for mmcm_reconfig_ctrl with a DRP/MMCM model.
//               Define MMCM_RECONFIG_READBACK_EN to cover the readback path.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mmcm_reconfig_ctrl;

`ifdef MMCM_RECONFIG_READBACK_EN
  localparam int RD_PER = 2;
`else
  localparam int RD_PER = 1;
`endif

  logic        clk_in = 1'b0;
  logic        reset, start;
  logic [1:0]  cfg_sel;
  logic        busy, done, error, mmcm_rst, den, dwe, drdy, locked, locked_out;
  logic [1:0]  err_code;
  logic [6:0]  daddr;
  logic [15:0] di, do_in;

  always #5 clk_in = ~clk_in;

  mmcm_reconfig_ctrl dut (
    .clk_in(clk_in), .reset(reset), .start(start), .cfg_sel(cfg_sel),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .mmcm_rst(mmcm_rst), .daddr(daddr), .di(di), .den(den), .dwe(dwe),
    .do_in(do_in), .drdy(drdy), .locked(locked), .locked_out(locked_out)
  );

  // DRP / MMCM behavioural model
  logic        mdl_clr, never_lock;
  int          block_at, corrupt_at;
  logic [15:0] mem [0:127];
  logic [127:0] mem_vld;
  logic [15:0] rdata;
  int          pend, rd_cnt, wr_cnt, den_overlap, lk_cnt;
  logic        prev_den;
  logic [6:0]  wr_addr [0:255];
  logic [15:0] wr_data [0:255];
  logic        wr_rst  [0:255];

  assign do_in = rdata;

  always @(posedge clk_in) begin
    drdy     <= 1'b0;
    prev_den <= den;
    if (mdl_clr) begin
      mem_vld <= '0; rd_cnt <= 0; wr_cnt <= 0; pend <= 0; den_overlap <= 0;
      rdata <= 16'h0;
    end else begin
      if (den && prev_den) den_overlap <= den_overlap + 1;
      if (pend != 0) begin
        pend <= pend - 1;
        if (pend == 1) drdy <= 1'b1;
      end
      if (den) begin
        if (dwe) begin
          mem[daddr] <= di; mem_vld[daddr] <= 1'b1;
          wr_addr[wr_cnt[7:0]] <= daddr;
          wr_data[wr_cnt[7:0]] <= di;
          wr_rst[wr_cnt[7:0]]  <= mmcm_rst;
          wr_cnt <= wr_cnt + 1;
          pend   <= 3;
        end else begin
          rd_cnt <= rd_cnt + 1;
          rdata  <= (mem_vld[daddr] ? mem[daddr] : 16'hB3C5) ^
                    ((rd_cnt + 1 == corrupt_at) ? 16'h0001 : 16'h0000);
          if (rd_cnt + 1 != block_at) pend <= 3;
        end
      end
    end
  end

  always @(posedge clk_in) begin
    if (mmcm_rst) begin
      locked <= 1'b0; lk_cnt <= 0;
    end else if (lk_cnt < 100) begin
      lk_cnt <= lk_cnt + 1;
    end else if (!never_lock) begin
      locked <= 1'b1;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] c);
    start = 1'b1; cfg_sel = c;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_end(input int max, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      step(1);
      if (done || error) begin ok = 1'b1; break; end
    end
  endtask

  logic [6:0]  exp_addr [0:3];
  logic [15:0] exp_di   [0:3];
  int          base_w, base_r, k;
  logic        ok;

  initial begin
    // cfg 1 over a model preloaded with 16'hB3C5: (B3C5 & mask) | data
    exp_addr[0] = 7'h08; exp_di[0] = 16'h1082;
    exp_addr[1] = 7'h09; exp_di[1] = 16'hB000;
    exp_addr[2] = 7'h14; exp_di[2] = 16'h1186;
    exp_addr[3] = 7'h16; exp_di[3] = 16'h9041;

    reset = 1'b1; start = 1'b0; cfg_sel = 2'd0; never_lock = 1'b0;
    block_at = 0; corrupt_at = 0; mdl_clr = 1'b1;
    step(3);
    mdl_clr = 1'b0;
    check("rst_busy", busy, 0);         check("rst_done", done, 0);
    check("rst_error", error, 0);       check("rst_err_code", err_code, 0);
    check("rst_den", den, 0);           check("rst_dwe", dwe, 0);
    check("rst_daddr", daddr, 0);       check("rst_di", di, 0);
    check("rst_mmcm_rst", mmcm_rst, 1); check("rst_locked_out", locked_out, 0);
    reset = 1'b0;
    step(1);
    check("idle_rst_drop", mmcm_rst, 0);
    step(110);
    check("idle_locked_out", locked_out, 1);

    // Normal cfg 1 reconfiguration
    base_w = wr_cnt; base_r = rd_cnt;
    pulse_start(2'd1);
    check("run_busy", busy, 1);
    check("run_locked_gated", locked_out, 0);
    check("run_mmcm_rst", mmcm_rst, 1);
    wait_end(2000, ok);
    check("run_end_seen", ok, 1);
    check("run_done", done, 1);         check("run_error", error, 0);
    check("run_busy_low", busy, 0);     check("run_locked_out", locked_out, 1);
    check("run_writes", wr_cnt - base_w, 4);
    check("run_reads", rd_cnt - base_r, 4 * RD_PER);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("run_wr%0d_addr", i), wr_addr[base_w + i], exp_addr[i]);
      check($sformatf("run_wr%0d_di", i), wr_data[base_w + i], exp_di[i]);
      check($sformatf("run_wr%0d_rst", i), wr_rst[base_w + i], 1);
    end
    step(1);
    check("done_pulse", done, 0);

    // start with cfg 3 while in WR_WAIT must be ignored
    base_w = wr_cnt; base_r = rd_cnt;
    pulse_start(2'd1);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (den && dwe) begin ok = 1'b1; break; end
      step(1);
    end
    check("ign_wr_seen", ok, 1);
    start = 1'b1; cfg_sel = 2'd3;
    step(1);
    start = 1'b0;
    check("ign_busy", busy, 1);
    wait_end(2000, ok);
    check("ign_done", ok & done, 1);
    check("ign_writes", wr_cnt - base_w, 4);
    check("ign_reads", rd_cnt - base_r, 4 * RD_PER);
    for (int i = 0; i < 4; i++)
      check($sformatf("ign_wr%0d_di", i), wr_data[base_w + i], exp_di[i]);

    // No drdy on the 2nd read -> drdy timeout after 64 wait cycles
    step(3);
    block_at = rd_cnt + 2;
    pulse_start(2'd0);
    k = 0; ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (den && !dwe) k++;
      if (k == 2) begin ok = 1'b1; break; end
      step(1);
    end
    check("to_rd2_seen", ok, 1);
    k = 0;
    for (int i = 0; i < 200; i++) begin
      step(1); k++;
      if (error) break;
    end
    check("to_cycles", k, 64);
    check("to_err_code", err_code, 1);  check("to_busy", busy, 0);
    check("to_mmcm_rst", mmcm_rst, 0);  check("to_done", done, 0);
    step(1);
    check("to_err_sticky", error, 1);
    block_at = 0;

    // MMCM never locks -> lock timeout after 65535 cycles
    never_lock = 1'b1;
    step(2);
    pulse_start(2'd0);
    check("lk_err_cleared", error, 0);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      step(1);
      if (!mmcm_rst) begin ok = 1'b1; break; end
    end
    check("lk_rst_release", ok, 1);
    k = 0;
    for (int i = 0; i < 70000; i++) begin
      step(1); k++;
      if (error || done) break;
    end
    check("lk_cycles", k, 65535);
    check("lk_err_code", err_code, 2);  check("lk_error", error, 1);
    never_lock = 1'b0;
    step(1);
    pulse_start(2'd2);
    check("lk_restart_error", error, 0);
    check("lk_restart_code", err_code, 0);
    check("lk_restart_busy", busy, 1);
    wait_end(2000, ok);
    check("lk_restart_done", ok & done, 1);

    // Reset while in WR of entry 2
    step(2);
    base_w = wr_cnt; base_r = rd_cnt;
    pulse_start(2'd2);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (rd_cnt == base_r + 2 * RD_PER + 1 && drdy) begin ok = 1'b1; break; end
    end
    check("mr_rd2_drdy", ok, 1);
    step(1);
    reset = 1'b1;
    step(1);
    check("mr_busy", busy, 0);          check("mr_done", done, 0);
    check("mr_error", error, 0);        check("mr_err_code", err_code, 0);
    check("mr_den", den, 0);            check("mr_dwe", dwe, 0);
    check("mr_daddr", daddr, 0);        check("mr_di", di, 0);
    check("mr_mmcm_rst", mmcm_rst, 1);  check("mr_locked_out", locked_out, 0);
    check("mr_writes", wr_cnt - base_w, 2);
    reset = 1'b0;
    step(3);

`ifdef MMCM_RECONFIG_READBACK_EN
    // Corrupted readback of entry 0 -> readback mismatch
    corrupt_at = rd_cnt + 2;
    pulse_start(2'd0);
    wait_end(2000, ok);
    check("rb_end_seen", ok, 1);
    check("rb_err_code", err_code, 3);
    check("rb_error", error, 1);
    corrupt_at = 0;
`endif

    check("den_no_back_to_back", den_overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mmcm_reconfig_ctrl.md
MMCM_RECONFIG_CTRL -- requirements
Module: mmcm_reconfig_ctrl

Interface
REQ-001 Parameter: N_ENTRIES, default 4, meaning DRP read-modify-write entries per configuration (1..16).
REQ-002 Parameter: DRDY_TIMEOUT, default 64, meaning maximum cycles from den to drdy before an error.
REQ-003 Parameter: LOCK_TIMEOUT, default 65535, meaning maximum cycles from mmcm_rst release to synchronised lock before an error.
REQ-004 Parameter: RST_CYCLES, default 8, meaning cycles mmcm_rst is held high before release.
REQ-005 Ports, one per line: name, direction, width, meaning.
- clk_in  in  1  single clock; also drives the MMCM DCLK.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to apply configuration cfg_sel.
- cfg_sel  in  2  configuration index, sampled on accepted start.
- busy  out  1  high from accepted start until done or error.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky; cleared by the next accepted start or by reset.
- err_code  out  2  0 none, 1 drdy timeout, 2 lock timeout, 3 readback mismatch.
- mmcm_rst  out  1  drives MMCM RST.
- daddr  out  7  DRP address.
- di  out  16  DRP write data.
- den  out  1  DRP enable.
- dwe  out  1  DRP write enable.
- do_in  in  16  DRP read data.
- drdy  in  1  DRP ready.
- locked  in  1  MMCM LOCKED, asynchronous to clk_in.
- locked_out  out  1  synchronised lock, gated low while busy.

Function
REQ-006 locked SHALL pass through a 2-flop synchroniser (lock_s); locked_out = lock_s & ~busy.
REQ-007 FSM states SHALL be IDLE, RST_ASSERT, RD, RD_WAIT, WR, WR_WAIT, CHK (macro only), NEXT, RST_HOLD, LOCK_WAIT, DONE, ERR.
REQ-008 IDLE: start=1 SHALL latch cfg_sel, clear error/err_code, set busy next cycle, clear idx, and go to RST_ASSERT; start while busy SHALL be ignored.
REQ-009 RST_ASSERT: mmcm_rst=1; go to RD; mmcm_rst SHALL stay 1 through all DRP states until RST_HOLD completes.
REQ-010 RD: den=1, dwe=0, daddr=rom_addr[idx] for exactly one cycle; then go to RD_WAIT.
REQ-011 RD_WAIT: on drdy, capture new = (do_in & rom_mask[idx]) | rom_data[idx] and go to WR.
REQ-012 Mask semantics: a mask bit of 1 SHALL keep the read bit; rom_data bits under mask=1 SHALL be 0.
REQ-013 WR: den=1, dwe=1, daddr=rom_addr[idx], di=new for one cycle; then go to WR_WAIT.
REQ-014 WR_WAIT: on drdy, go to CHK (macro defined) or NEXT.
REQ-015 NEXT: if idx==N_ENTRIES-1 go to RST_HOLD, else idx+1 and go to RD.
REQ-016 RST_HOLD: keep mmcm_rst=1 for RST_CYCLES cycles, then mmcm_rst=0 and go to LOCK_WAIT.
REQ-017 LOCK_WAIT: lock_s=1 SHALL go to DONE; the LOCK_TIMEOUT-th cycle without lock SHALL go to ERR with err_code=2.
REQ-018 DONE: done=1 for one cycle, busy=0, go to IDLE.
REQ-019 In RD_WAIT/WR_WAIT the DRDY_TIMEOUT-th cycle without drdy SHALL go to ERR with err_code=1.
REQ-020 ERR: error=1, busy=0, mmcm_rst=0, go to IDLE next cycle.
REQ-021 drdy outside RD_WAIT/WR_WAIT SHALL be ignored; den SHALL never be high on two consecutive cycles.
REQ-022 Timeout counters SHALL be 16 bits, cleared on state entry, and saturating.
REQ-023 DRP outputs SHALL be registered; daddr/di SHALL hold their last value while den=0.

Reset
REQ-024 Reset values: FSM=IDLE, busy=0, done=0, error=0, err_code=0, den=0, dwe=0, daddr=0, di=0, idx=0, synchroniser=0, locked_out=0, mmcm_rst=1.
REQ-025 After reset deasserts, mmcm_rst SHALL drop in the first IDLE cycle.
REQ-026 Reset mid-sequence SHALL abort without undoing partial DRP writes; recovery is by a new start.

Configuration
REQ-027 With MMCM_RECONFIG_READBACK_EN defined, CHK SHALL re-read daddr (one den cycle, with DRDY timeout); a mismatch with new SHALL go to ERR with err_code=3, a match SHALL go to NEXT.
REQ-028 Without MMCM_RECONFIG_READBACK_EN, CHK SHALL be absent, err_code=3 SHALL be unreachable, and WR_WAIT SHALL go straight to NEXT.

Structure
REQ-029 Package mmcm_reconfig_pkg SHALL hold the FSM state enum, the err_code constants, the DRP address constants (CLKOUT0/CLKOUT2 reg1/reg2, CLKFBOUT, DIVCLK), and the ROM entry struct {addr 7, mask 16, data 16}.
REQ-030 Sub-module mmcm_cfg_rom SHALL be a combinational lookup (cfg_sel, idx) -> entry holding 4 configurations x N_ENTRIES entries.

Verification
REQ-031 Bench SHALL use a DRP/MMCM behavioural model with a 3-cycle drdy latency and lock asserted 100 cycles after RST falls.
REQ-032 cfg_sel=1, start -> 4 reads and 4 writes with di=(model&mask)|data, mmcm_rst high through all writes, done after lock, locked_out=1.
REQ-033 Model never asserts drdy on the 2nd read -> ERR at cycle 64 of RD_WAIT, err_code=1, busy=0, mmcm_rst=0.
REQ-034 Model never locks -> err_code=2 after 65535 LOCK_WAIT cycles; the next start clears error.
REQ-035 start pulsed during WR_WAIT with cfg_sel=3 -> ignored; the sequence completes with the cfg 1 data.
REQ-036 Reset asserted in WR of entry 2 -> all outputs at reset values the next cycle, mmcm_rst=1; with the macro defined, the model corrupting a readback -> err_code=3.
